alu_div_seq: RTL and testbench

// Iterative 32-bit unsigned restoring divider. It is the initiator side of the
// alu32 operand/function/flag interface: it drives A, B and F and consumes Y and FLAGS.
// One subtract per cycle is issued to an external alu32 instance, and the carry flag

---
 rtl/alu_div_seq.sv | 123 ++++++++++++
 tb/tb_alu_div_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_div_seq.sv
// Iterative 32-bit unsigned restoring divider that borrows an external alu32
// for its per-cycle trial subtract; one quotient bit is resolved per RUN cycle.
module alu_div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [3:0]       alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_d, q_d;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] sh;
  logic             take;
  logic             unused_flags;

  // N, Z and V from the ALU carry no information for an unsigned restoring step.
  assign unused_flags = &{1'b0, alu_flags[3:2], alu_flags[0]};

  // A set R msb means the shifted value is 33 bits wide and certainly >= D;
  // the low 32 bits of the ALU difference are still exact in that case.
  always_comb begin
    sh   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    take = r_q[WIDTH-1] | alu_flags[1];
    r_d  = take ? alu_y : sh;
    q_d  = {q_q[WIDTH-2:0], take};
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = 2'b00;
    if (state_q == S_RUN) begin
      alu_a = sh;
      alu_b = d_q;
      alu_f = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              q_q     <= dividend;
              d_q     <= divisor;
              r_q     <= '0;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq with a behavioural alu32 answering its requests.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [1:0]  alu_f;
  logic [3:0]  alu_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural alu32: F=00 add, F=01 subtract, F=10 and, F=11 or.
  logic [32:0] sum33;
  logic        ovf;
  always_comb begin
    sum33 = '0;
    ovf   = 1'b0;
    case (alu_f)
      2'b00: begin
        sum33 = {1'b0, alu_a} + {1'b0, alu_b};
        ovf   = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
      end
      2'b01: begin
        sum33 = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        ovf   = (alu_a[31] != alu_b[31]) && (sum33[31] != alu_a[31]);
      end
      2'b10:   sum33 = {1'b0, alu_a & alu_b};
      default: sum33 = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_y     = sum33[31:0];
  assign alu_flags = {sum33[31], sum33[31:0] == 32'd0, sum33[32], ovf};

  alu_div_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_y     (alu_y),
    .alu_flags (alu_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and wait (bounded) for done; restart_at > 0 pulses a
  // second start with other operands at that RUN cycle, which must be ignored.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_dz, input int exp_lat, input int restart_at);
    int cycles;
    int dones;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (b != 32'd0) begin
      check({tag, "_dz_clr"}, {31'd0, div_zero}, 32'd0);
      check({tag, "_alu_a0"}, alu_a, {31'd0, a[31]});
      check({tag, "_alu_b"}, alu_b, b);
      check({tag, "_alu_f"}, {30'd0, alu_f}, 32'd1);
    end
    cycles = 0;
    while (!done && cycles < 40) begin
      if (restart_at > 0 && cycles == restart_at) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      step();
      start = 1'b0;
      cycles++;
    end
    check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_quot"}, quotient, exp_q);
    check({tag, "_rem"}, remainder, exp_r);
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
    check({tag, "_alu_f_done"}, {30'd0, alu_f}, 32'd0);
    // start coincident with done must be ignored as well
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      if (done) dones++;
    end
    check({tag, "_single_done"}, dones, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold_q"}, quotient, exp_q);
    check({tag, "_hold_r"}, remainder, exp_r);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_f", {30'd0, alu_f}, 32'd0);
    reset_n = 1'b1;
    step();

    do_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 0);
    do_div("max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 0);
    do_div("msb", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 32, 0);
    do_div("dz", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0, 0);
    do_div("restart", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 10);

    // Abort a run with an asynchronous reset partway through.
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quot", quotient, 32'd0);
    check("abort_rem", remainder, 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    check("abort_alu_f", {30'd0, alu_f}, 32'd0);
    step();
    #2 reset_n = 1'b1;
    step();
    check("post_rst_done", {31'd0, done}, 32'd0);
    do_div("d50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
